// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter sharing one 32-bit ALU, with a registered
// valid/ready response. Define ALU_ARB_STRICT_PRIO_EN to make requester 0 always win.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic [3:0]        rsp_flags
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t              r_state;
    logic                r_id;
    logic                r_last_grant;
    logic [DATA_W-1:0]   r_result;
    logic [3:0]          r_flags;

    logic                w_can_accept;
    logic                w_grant0;
    logic                w_grant1;
    logic                w_xfer;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [OP_W-1:0]     w_op;
    logic [DATA_W-1:0]   w_b_inv;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_diff;
    logic [DATA_W-1:0]   w_result;
    logic                w_ovf;
    logic                w_carry;
    logic [3:0]          w_flags;

    assign w_can_accept = (r_state == EMPTY) | rsp_ready;

`ifdef ALU_ARB_STRICT_PRIO_EN
    assign w_grant1 = req1_valid & ~req0_valid;
`else
    // On contention, favour the requester that was not granted last.
    assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
`endif
    assign w_grant0 = req0_valid & ~w_grant1;

    // Readies are forced low while reset is asserted.
    assign req0_ready = rst_n & w_can_accept & w_grant0;
    assign req1_ready = rst_n & w_can_accept & w_grant1;
    assign w_xfer     = req0_ready | req1_ready;

    assign w_a  = w_grant1 ? req1_a  : req0_a;
    assign w_b  = w_grant1 ? req1_b  : req0_b;
    assign w_op = w_grant1 ? req1_op : req0_op;

    assign w_b_inv = w_op[0] ? ~w_b : w_b;
    assign w_sum   = {1'b0, w_a} + {1'b0, w_b_inv} + {{DATA_W{1'b0}}, w_op[0]};
    assign w_diff  = w_a + ~w_b + {{(DATA_W-1){1'b0}}, 1'b1};

    always_comb begin
        w_result = w_sum[DATA_W-1:0];
        case (w_op)
            3'b010:  w_result = w_a & w_b;
            3'b011:  w_result = w_a | w_b;
            3'b101:  w_result = {{(DATA_W-1){1'b0}}, w_diff[DATA_W-1]};
            default: w_result = w_sum[DATA_W-1:0];
        endcase
    end

    assign w_ovf   = ~(w_a[DATA_W-1] ^ w_b[DATA_W-1] ^ w_op[0])
                   & (w_a[DATA_W-1] ^ w_sum[DATA_W-1]) & ~w_op[1];
    assign w_carry = ~w_op[1] & w_sum[DATA_W];
    assign w_flags = {w_ovf, w_carry, w_result[DATA_W-1], (w_result == '0)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= EMPTY;
            r_id         <= 1'b0;
            r_result     <= '0;
            r_flags      <= '0;
            r_last_grant <= 1'b1;
        end else if (w_xfer) begin
            r_state      <= FULL;
            r_id         <= w_grant1;
            r_result     <= w_result;
            r_flags      <= w_flags;
            r_last_grant <= w_grant1;
        end else if (r_state == FULL && rsp_ready) begin
            r_state      <= EMPTY;
        end
    end

    assign rsp_valid  = (r_state == FULL);
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_flags  = r_flags;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: per-cycle comparison against a
// behavioural model plus hand-computed literal checks.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a, req0_b;
    logic [2:0]  req0_op;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a, req1_b;
    logic [2:0]  req1_op;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;

    int n_chk = 0;
    int n_fail = 0;

    alu_share_arbiter #(.DATA_W(32), .OP_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU: returns {flags, result} with flags = {ovf, carry, neg, zero}.
    function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        logic [31:0] r;
        logic        ov, c;
        longint      sa, sb, sr;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        ov = 1'b0;
        c  = 1'b0;
        if (op == 3'b010) r = a & b;
        else if (op == 3'b011) r = a | b;
        else if (op[0]) begin
            r = a - b;
            sr = sa - sb;
            if (!op[1]) begin
                c  = (a >= b);
                ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            if (op == 3'b101) r = {31'b0, r[31]};
        end else begin
            r = a + b;
            sr = sa + sb;
            if (!op[1]) begin
                c  = (ua + ub) > 64'hFFFF_FFFF;
                ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
        end
        return {ov, c, r[31], (r == 32'd0), r};
    endfunction

    // Model state: the held response and the round-robin pointer.
    logic        m_valid, m_id, m_last;
    logic [31:0] m_res;
    logic [3:0]  m_flags;

    initial begin
        logic        e_r0, e_r1, g1, can, n_valid, n_id, n_last;
        logic [31:0] n_res;
        logic [3:0]  n_flags;
        logic [35:0] alu;
        m_valid = 0; m_id = 0; m_last = 1; m_res = 0; m_flags = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_valid = 0; m_id = 0; m_last = 1; m_res = 0; m_flags = 0;
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_id", rsp_id, 0);
                chk("rst_rsp_result", rsp_result, 0);
                chk("rst_rsp_flags", rsp_flags, 0);
                chk("rst_ready0", req0_ready, 0);
                chk("rst_ready1", req1_ready, 0);
            end else begin
                can = !m_valid || rsp_ready;
`ifdef ALU_ARB_STRICT_PRIO_EN
                g1 = req1_valid && !req0_valid;
`else
                g1 = req1_valid && (!req0_valid || m_last == 1'b0);
`endif
                e_r1 = can && g1;
                e_r0 = can && req0_valid && !g1;
                chk("ready0", req0_ready, e_r0);
                chk("ready1", req1_ready, e_r1);
                chk("rsp_valid", rsp_valid, m_valid);
                if (m_valid) begin
                    chk("rsp_id", rsp_id, m_id);
                    chk("rsp_result", rsp_result, m_res);
                    chk("rsp_flags", rsp_flags, m_flags);
                end
                n_valid = m_valid; n_id = m_id; n_last = m_last;
                n_res = m_res; n_flags = m_flags;
                if (e_r0 || e_r1) begin
                    alu = e_r1 ? ref_alu(req1_a, req1_b, req1_op) : ref_alu(req0_a, req0_b, req0_op);
                    n_valid = 1; n_id = e_r1; n_last = e_r1;
                    n_res = alu[31:0]; n_flags = alu[35:32];
                end else if (m_valid && rsp_ready) begin
                    n_valid = 0;
                end
            end
            @(posedge clk);
            if (rst_n) begin
                m_valid = n_valid; m_id = n_id; m_last = n_last;
                m_res = n_res; m_flags = n_flags;
            end
        end
    end

    task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [2:0] op0, input logic v1, input logic [31:0] a1,
                         input logic [31:0] b1, input logic [2:0] op1, input logic rr);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        rsp_ready = rr;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic exp_ids [4];

    initial begin
`ifdef ALU_ARB_STRICT_PRIO_EN
        exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        rst_n = 1'b0;
        drive(1, 32'h1, 32'h2, 3'b000, 1, 32'h3, 32'h4, 3'b000, 1);
        cyc();
        chk("reset_ready0", req0_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc();
        rst_n = 1'b1;

        drive(1, 32'h7FFF_FFFF, 32'h1, 3'b000, 0, 0, 0, 0, 1);
        #1 chk("add_ready0", req0_ready, 1);
        cyc();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("add_id", rsp_id, 0);
        chk("add_result", rsp_result, 32'h8000_0000);
        chk("add_flags", rsp_flags, 4'b1010);

        drive(0, 0, 0, 0, 1, 32'd5, 32'd5, 3'b001, 1);
        cyc();
        chk("sub_id", rsp_id, 1);
        chk("sub_result", rsp_result, 0);
        chk("sub_flags", rsp_flags, 4'b0101);

        drive(0, 0, 0, 0, 1, 32'd3, 32'd7, 3'b101, 1);
        cyc();
        chk("slt_result", rsp_result, 1);
        chk("slt_flags", rsp_flags, 4'b0000);

        drive(1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b010, 0, 0, 0, 0, 1);
        cyc();
        chk("and_result", rsp_result, 32'h00F0_00F0);
        chk("and_flags", rsp_flags, 4'b0000);

        drive(0, 0, 0, 0, 1, 32'd0, 32'd0, 3'b011, 1);
        cyc();
        chk("or_result", rsp_result, 0);
        chk("or_flags", rsp_flags, 4'b0001);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc();
        chk("drain_valid", rsp_valid, 0);

        drive(1, 32'd1, 32'd2, 3'b000, 1, 32'd9, 32'd4, 3'b001, 1);
        for (int i = 0; i < 4; i++) begin
            #1 chk("rr_one_ready", req0_ready ^ req1_ready, 1);
            cyc();
            chk($sformatf("rr_id%0d", i), rsp_id, exp_ids[i]);
        end

        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_ready0", req0_ready, 0);
            chk("stall_ready1", req1_ready, 0);
            cyc();
            chk("stall_valid", rsp_valid, 1);
`ifdef ALU_ARB_STRICT_PRIO_EN
            chk("stall_result", rsp_result, 32'd3);
`else
            chk("stall_result", rsp_result, 32'd5);
`endif
        end
        rsp_ready = 1'b1;
        #1 chk("unstall_ready0", req0_ready, 1);
        cyc();
        chk("b2b_valid", rsp_valid, 1);
        chk("b2b_id", rsp_id, 0);
        chk("b2b_result", rsp_result, 32'd3);

        rsp_ready = 1'b0;
        cyc();
        #2 rst_n = 1'b0;
        #1 chk("async_valid", rsp_valid, 0);
        chk("async_result", rsp_result, 0);
        chk("async_flags", rsp_flags, 0);
        chk("async_id", rsp_id, 0);
        chk("async_ready1", req1_ready, 0);
        cyc();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1 chk("post_rst_ready0", req0_ready, 1);
        chk("post_rst_ready1", req1_ready, 0);
        cyc();
        chk("post_rst_id", rsp_id, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter that time-shares a single 32-bit ALU datapath (add, sub, and, or, slt, plus overflow/carry/negative/zero flags). It sits between the execute-stage issue logic and the ALU, so that two independent issue sources (e.g. main pipe and address-generation/branch-compare helper) share one adder. It registers each result and its flags behind a valid/ready response channel tagged with the requester ID.

## Interface
- DATA_W, 32, operand/result width; only 32 supported.
- OP_W, 3, ALU control width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  DATA_W  requester 0 operands.
- req0_op  in  OP_W  requester 0 ALU control.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- rsp_valid  out  1  result register holds a result.
- rsp_ready  in  1  consumer takes result this cycle.
- rsp_id  out  1  requester that issued the held result.
- rsp_result  out  DATA_W  held result.
- rsp_flags  out  4  {overflow, carry, negative, zero} for held result.

## Operation
- ALU function of op: 010 = A&B; 011 = A|B; 101 = {31'b0, diff[31]} where diff = A + ~B + 1 (no overflow correction); all other codes = A + (op[0] ? ~B : B) + op[0] (000 add, 001 sub, 100 add, 110 add, 111 sub).
- Flags: overflow = ~(A[31]^B[31]^op[0]) & (A[31]^sum[31]) & ~op[1]; carry = ~op[1] & carry-out of 33-bit sum; negative = result[31]; zero = (result == 0). Flags are computed from the selected requester's operands and registered with the result.
- Output stage: two states, EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = ~rsp_valid | rsp_ready.
- Arbitration is round-robin: pointer last_grant (1 bit). If both valid, grant the requester ≠ last_grant; if one valid, grant it. last_grant updates to the granted ID only on an accepted transfer.
- reqN_ready = grantN & can_accept; at most one ready high per cycle; ready never high for a non-valid requester.
- Transfer when reqN_valid & reqN_ready: result, flags, and ID are loaded; state FULL.
- FULL & rsp_ready & no transfer -> EMPTY. FULL & rsp_ready & transfer -> stays FULL with new data (back-to-back). FULL & ~rsp_ready -> hold all rsp_* stable and both readies 0.
- Requesters must hold valid and operands stable until ready; the arbiter does not buffer or retract a grant once ready is high.

## Timing
- Reset (rst_n=0, async): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, last_grant=1; req0_ready=req1_ready=0 while rst_n is low.
- First cycle after reset with both valid: requester 0 granted.
- Latency: transfer at edge N -> rsp_valid/result visible after edge N, i.e. in cycle N+1.
- Throughput: one operation per cycle while rsp_ready stays high.
- Ready paths are combinational from reqN_valid and rsp_ready; the ALU is combinational from the granted operands into the result register.
- Reset asserted mid-operation: held result discarded immediately; no response is produced for the in-flight operation.

## Configuration
- ALU_ARB_STRICT_PRIO_EN defined: requester 0 always wins when both are valid; last_grant is still maintained but ignored by arbitration.
- Undefined (default): round-robin as described above.

## Test plan
- Reset, then req0 add A=0x7FFFFFFF B=1, rsp_ready=1 -> next cycle rsp_id=0, rsp_result=0x80000000, flags overflow=1 carry=0 negative=1 zero=0.
- req1 sub A=5 B=5 -> rsp_result=0, flags zero=1 carry=1 overflow=0; req1 slt A=3 B=7 -> rsp_result=1.
- Both valid continuously for 4 cycles, rsp_ready=1 -> grants 0,1,0,1, one ready per cycle, rsp_id sequence 0,1,0,1 (with STRICT_PRIO_EN: 0,0,0,0).
- rsp_ready=0 for 3 cycles with result held, both requesters valid -> rsp_* stable, both readies 0; rsp_ready=1 -> same-cycle accept of the next operation, back-to-back FULL.
- Reset pulsed low while FULL with rsp_ready=0 -> rsp_valid drops immediately and all rsp_* are 0; after release, first grant goes to requester 0.
- AND 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0, carry=0 overflow=0; OR of 0 with 0 -> 0, zero=1.
